// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter (with helper priority_encoder)
// Brief    : Registered round-robin / fixed-priority arbiter with hold-on-ack
//            or hold-while-requesting grant release.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_encoder #(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 1
) (
  input  logic [WIDTH-1:0]         input_unencoded,
  output logic                     output_valid,
  output logic [$clog2(WIDTH)-1:0] output_encoded
);

  localparam int c_W = $clog2(WIDTH);

  always_comb begin
    output_valid   = |input_unencoded;
    output_encoded = '0;
    // Scan from the losing end so the last hit is the winner.
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (input_unencoded[i]) output_encoded = c_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (input_unencoded[i]) output_encoded = c_W'(i);
      end
    end
  end

endmodule

module rr_arbiter #(
  parameter int PORTS             = 4,
  parameter int ROUND_ROBIN       = 1,
  parameter int BLOCK_ACK         = 1,
  parameter int LSB_HIGH_PRIORITY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded
);

  localparam int c_W = $clog2(PORTS);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_t;

  state_t           r_state;
  logic [PORTS-1:0] r_grant;
  logic [PORTS-1:0] r_mask;
  logic [c_W-1:0]   r_enc;

  logic             w_req_valid;
  logic [c_W-1:0]   w_req_enc;
  logic [c_W-1:0]   w_win_enc;
  logic [PORTS-1:0] w_next_mask;
  logic             w_hold;

  priority_encoder #(
    .WIDTH            (PORTS),
    .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)
  ) u_pe_req (
    .input_unencoded(request),
    .output_valid   (w_req_valid),
    .output_encoded (w_req_enc)
  );

  generate
    if (ROUND_ROBIN != 0) begin : g_rr
      logic           w_msk_valid;
      logic [c_W-1:0] w_msk_enc;

      priority_encoder #(
        .WIDTH            (PORTS),
        .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)
      ) u_pe_msk (
        .input_unencoded(request & r_mask),
        .output_valid   (w_msk_valid),
        .output_encoded (w_msk_enc)
      );

      // An empty masked set means the rotation wrapped past the last port.
      assign w_win_enc = w_msk_valid ? w_msk_enc : w_req_enc;
    end else begin : g_fixed
      assign w_win_enc = w_req_enc;
    end
  endgenerate

  always_comb begin
    w_next_mask = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (LSB_HIGH_PRIORITY != 0) w_next_mask[i] = (c_W'(i) > w_win_enc);
      else                        w_next_mask[i] = (c_W'(i) < w_win_enc);
    end
  end

  assign w_hold = (r_state == ST_GRANTED) &&
                  ((BLOCK_ACK != 0) ? !acknowledge[r_enc] : request[r_enc]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_enc   <= '0;
      r_mask  <= '1;
    end else if (!w_hold) begin
      if (w_req_valid) begin
        r_state <= ST_GRANTED;
        r_grant <= {{(PORTS-1){1'b0}}, 1'b1} << w_win_enc;
        r_enc   <= w_win_enc;
        r_mask  <= w_next_mask;
      end else begin
        r_state <= ST_IDLE;
        r_grant <= '0;
        r_enc   <= '0;
      end
    end
  end

  assign grant         = r_grant;
  assign grant_encoded = r_enc;
  assign grant_valid   = (r_state == ST_GRANTED);

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter.sv
// ============================================================================
// Module   : tb_rr_arbiter
// Brief    : Directed self-checking bench for rr_arbiter (ack, level, fixed).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;

  // Default build: round-robin, block-on-ack
  logic [3:0] req_a = '0, ack_a = '0, gnt_a;
  logic [1:0] enc_a;
  logic       vld_a;
  // Level-hold build
  logic [3:0] req_l = '0, ack_l = '0, gnt_l;
  logic [1:0] enc_l;
  logic       vld_l;
  // Fixed-priority build
  logic [3:0] req_f = '0, ack_f = '0, gnt_f;
  logic [1:0] enc_f;
  logic       vld_f;

  always #5 clk = ~clk;

  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1)) u_dut (
    .clk(clk), .rst(rst), .request(req_a), .acknowledge(ack_a),
    .grant(gnt_a), .grant_valid(vld_a), .grant_encoded(enc_a));

  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1)) u_dut_lvl (
    .clk(clk), .rst(rst), .request(req_l), .acknowledge(ack_l),
    .grant(gnt_l), .grant_valid(vld_l), .grant_encoded(enc_l));

  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(0), .BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1)) u_dut_fp (
    .clk(clk), .rst(rst), .request(req_f), .acknowledge(ack_f),
    .grant(gnt_f), .grant_valid(vld_f), .grant_encoded(enc_f));

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_a = '0; ack_a = '0; req_l = '0; ack_l = '0; req_f = '0; ack_f = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({vld_a, enc_a, gnt_a} !== 7'b0_00_0000) begin
      errors++;
      $display("FAIL reset_a: got v/e/g=%b expected 0_00_0000", {vld_a, enc_a, gnt_a});
    end
    checks++;
    if ({vld_l, enc_l, gnt_l, vld_f, enc_f, gnt_f} !== 14'b0) begin
      errors++;
      $display("FAIL reset_lf: got %b expected all zero", {vld_l, enc_l, gnt_l, vld_f, enc_f, gnt_f});
    end
  endtask

  task automatic test_first_grant();
    req_a = 4'b0101;
    tick();
    checks++;
    if ({vld_a, enc_a, gnt_a} !== 7'b1_00_0001) begin
      errors++;
      $display("FAIL first_grant: got v/e/g=%b expected 1_00_0001", {vld_a, enc_a, gnt_a});
    end
  endtask

  task automatic test_hold_block();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({vld_a, enc_a, gnt_a} !== 7'b1_00_0001) begin
        errors++;
        $display("FAIL hold_no_ack[%0d]: got %b expected 1_00_0001", k, {vld_a, enc_a, gnt_a});
      end
    end
    ack_a = 4'b0001;
    tick();
    ack_a = 4'b0000;
    checks++;
    if ({vld_a, enc_a, gnt_a} !== 7'b1_10_0100) begin
      errors++;
      $display("FAIL ack_release: got %b expected 1_10_0100", {vld_a, enc_a, gnt_a});
    end
    req_a = 4'b0000;
    ack_a = 4'b0100;
    tick();
    ack_a = 4'b0000;
    checks++;
    if ({vld_a, enc_a, gnt_a} !== 7'b0_00_0000) begin
      errors++;
      $display("FAIL idle_after_ack: got %b expected 0_00_0000", {vld_a, enc_a, gnt_a});
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    req_a = 4'b1111;
    tick();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({vld_a, enc_a} !== {1'b1, seq[k]}) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got v/e=%b expected %b", k, {vld_a, enc_a}, {1'b1, seq[k]});
      end
      ack_a = 4'b0001 << seq[k];
      tick();
      ack_a = 4'b0000;
    end
    req_a = 4'b0000;
    ack_a = 4'b0100;
    tick();
    ack_a = 4'b0000;
    checks++;
    if ({vld_a, enc_a, gnt_a} !== 7'b0_00_0000) begin
      errors++;
      $display("FAIL rr_drain: got %b expected 0_00_0000", {vld_a, enc_a, gnt_a});
    end
  endtask

  task automatic test_foreign_ack();
    do_reset();
    req_a = 4'b0010;
    tick();
    req_a = 4'b0000;
    ack_a = 4'b1000;
    tick();
    tick();
    checks++;
    if ({vld_a, enc_a, gnt_a} !== 7'b1_01_0010) begin
      errors++;
      $display("FAIL foreign_ack: got %b expected 1_01_0010", {vld_a, enc_a, gnt_a});
    end
    ack_a = 4'b0010;
    tick();
    ack_a = 4'b0000;
    checks++;
    if ({vld_a, enc_a, gnt_a} !== 7'b0_00_0000) begin
      errors++;
      $display("FAIL own_ack_idle: got %b expected 0_00_0000", {vld_a, enc_a, gnt_a});
    end
  endtask

  task automatic test_level_mode();
    req_l = 4'b0011;
    tick();
    checks++;
    if ({vld_l, enc_l, gnt_l} !== 7'b1_00_0001) begin
      errors++;
      $display("FAIL lvl_first: got %b expected 1_00_0001", {vld_l, enc_l, gnt_l});
    end
    // Acknowledge has no effect when holding on request level.
    ack_l = 4'b0001;
    tick();
    ack_l = 4'b0000;
    checks++;
    if ({vld_l, enc_l, gnt_l} !== 7'b1_00_0001) begin
      errors++;
      $display("FAIL lvl_ack_ignored: got %b expected 1_00_0001", {vld_l, enc_l, gnt_l});
    end
    req_l = 4'b0010;
    tick();
    checks++;
    if ({vld_l, enc_l, gnt_l} !== 7'b1_01_0010) begin
      errors++;
      $display("FAIL lvl_handoff: got %b expected 1_01_0010", {vld_l, enc_l, gnt_l});
    end
    req_l = 4'b0000;
    tick();
    checks++;
    if ({vld_l, enc_l, gnt_l} !== 7'b0_00_0000) begin
      errors++;
      $display("FAIL lvl_idle: got %b expected 0_00_0000", {vld_l, enc_l, gnt_l});
    end
  endtask

  task automatic test_fixed_priority();
    req_f = 4'b1111;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({vld_f, enc_f, gnt_f} !== 7'b1_00_0001) begin
        errors++;
        $display("FAIL fixed_prio[%0d]: got %b expected 1_00_0001", k, {vld_f, enc_f, gnt_f});
      end
      ack_f = 4'b0001;
      tick();
      ack_f = 4'b0000;
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_a = 4'b0101;
    tick();
    ack_a = 4'b0001;
    tick();
    ack_a = 4'b0000;
    checks++;
    if ({vld_a, enc_a, gnt_a} !== 7'b1_10_0100) begin
      errors++;
      $display("FAIL pre_reset_grant: got %b expected 1_10_0100", {vld_a, enc_a, gnt_a});
    end
    rst   = 1'b1;
    ack_a = 4'b0100;
    tick();
    checks++;
    if ({vld_a, enc_a, gnt_a} !== 7'b0_00_0000) begin
      errors++;
      $display("FAIL mid_reset: got %b expected 0_00_0000", {vld_a, enc_a, gnt_a});
    end
    rst   = 1'b0;
    ack_a = 4'b0000;
    req_a = 4'b1100;
    tick();
    checks++;
    if ({vld_a, enc_a, gnt_a} !== 7'b1_10_0100) begin
      errors++;
      $display("FAIL mask_after_reset: got %b expected 1_10_0100", {vld_a, enc_a, gnt_a});
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_hold_block();
    test_round_robin();
    test_foreign_ack();
    test_level_mode();
    test_fixed_priority();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of requesters; legal range 2..64.
REQ-002 SHALL have parameter ROUND_ROBIN, default 1; 1 = round-robin, 0 = fixed priority.
REQ-003 SHALL have parameter BLOCK_ACK, default 1; 1 = grant held until acknowledged, 0 = grant held while granted request stays high.
REQ-004 SHALL have parameter LSB_HIGH_PRIORITY, default 1; 1 = lowest index wins ties, 0 = highest index wins ties.
REQ-005 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port request  input  PORTS  per-port request level.
REQ-008 SHALL have port acknowledge  input  PORTS  per-port release strobe, BLOCK_ACK=1 only.
REQ-009 SHALL have port grant  output  PORTS  one-hot grant, or all-zero.
REQ-010 SHALL have port grant_valid  output  1  high when any grant bit is set.
REQ-011 SHALL have port grant_encoded  output  $clog2(PORTS)  binary index of the granted port.

Function
REQ-012 SHALL drive all outputs from registers; a grant SHALL appear exactly 1 cycle after the request that wins is sampled.
REQ-013 SHALL operate as two states: IDLE (grant_valid=0) and GRANTED (grant_valid=1, one grant bit set).
REQ-014 SHALL keep grant, grant_encoded and grant_valid mutually consistent every cycle: grant = 1<<grant_encoded when valid, grant=0 and grant_encoded=0 when not valid.
REQ-015 SHALL hold the current grant unchanged while BLOCK_ACK=1 and acknowledge[grant_encoded]=0, even if request[grant_encoded] drops.
REQ-016 SHALL hold the current grant unchanged while BLOCK_ACK=0 and request[grant_encoded]=1.
REQ-017 SHALL re-arbitrate in any cycle where no grant is held; the arbitration result becomes the grant on the next edge with no idle bubble between back-to-back grants.
REQ-018 SHALL, when re-arbitration sees request=0, go to IDLE on the next edge.
REQ-019 SHALL, in fixed-priority mode, pick the highest-priority asserted request per LSB_HIGH_PRIORITY.
REQ-020 SHALL, in round-robin mode, keep a mask register selecting ports strictly lower priority than the last granted port; pick the highest-priority request within request&mask if nonzero, else within request.
REQ-021 SHALL update the mask only when a new grant is issued; the mask SHALL wrap so that after the lowest-priority port the highest-priority port is eligible first.
REQ-022 SHALL ignore acknowledge bits of non-granted ports and all acknowledge bits while IDLE or when BLOCK_ACK=0.
REQ-023 SHALL allow the just-released port to win again in the same re-arbitration only if no other port is requesting.
REQ-024 SHALL implement the winner selection with the team priority_encoder (two instances in round-robin mode: masked and unmasked).

Reset
REQ-025 SHALL on rst=1 at a rising edge set grant=0, grant_valid=0, grant_encoded=0, mask=all-ones (port 0 highest first when LSB_HIGH_PRIORITY=1), regardless of state.
REQ-026 SHALL ignore request and acknowledge in any cycle where rst=1; first grant possible on the edge after rst deasserts with request asserted.

Verification (PORTS=4, LSB_HIGH_PRIORITY=1, ROUND_ROBIN=1 unless stated)
REQ-027 SHALL verify: reset, then request=0101 -> next cycle grant=0001, grant_encoded=0, grant_valid=1.
REQ-028 SHALL verify: BLOCK_ACK=1, request=0101 held 5 cycles with no ack -> grant stays 0001; acknowledge=0001 one cycle -> next cycle grant=0100, grant_encoded=2.
REQ-029 SHALL verify: request=1111 constant, ack every granted port on its first grant cycle -> grant_encoded sequence 0,1,2,3,0,1 with grant_valid never dropping.
REQ-030 SHALL verify: BLOCK_ACK=0, request=0011 -> grant 0001; request[0] drops -> next cycle grant=0010; all requests drop -> next cycle grant_valid=0, grant_encoded=0.
REQ-031 SHALL verify: BLOCK_ACK=1, grant=0010, request[1] drops and acknowledge=1000 -> grant stays 0010; ROUND_ROBIN=0 with request=1111 and repeated acks -> grant always 0001.
REQ-032 SHALL verify: rst asserted while grant=0100 -> next cycle all outputs zero; after release, request=1100 -> grant=0100 (mask reset, not continued).
